ex_hazard: RTL and testbench

EX_HAZARD -- requirements
Module: ex_hazard

---
 rtl/ex_hazard_pkg.sv | 40 ++++
 rtl/ex_hazard_fwd_sel.sv | 42 ++++
 rtl/ex_hazard.sv | 89 ++++++++
 tb/tb_ex_hazard.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_pkg.sv
// ============================================================
// Package : pipes
// Desc    : Shared pipeline types for EX-stage hazard control
// Rev     : 1.0  initial release
// ============================================================
`default_nettype none

package pipes;

   typedef enum logic [2:0] {
      Rd      = 3'd0,
      Result  = 3'd1,
      Wd      = 3'd2,
      PCplus4 = 3'd3,
      Sregwd  = 3'd4
   } forward_t;

   typedef enum logic [1:0] {
      ALU  = 2'd0,
      LOAD = 2'd1,
      LINK = 2'd2
   } wbsrc_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      wbsrc_t     kind;
   } hz_slot_t;

   localparam hz_slot_t c_empty_slot = '{valid: 1'b0, rd: 5'd0, regwrite: 1'b0, kind: ALU};

   // A slot produces a register only if it will really write a non-zero destination.
   function automatic logic writes_reg(hz_slot_t s, logic [4:0] r);
      return s.valid & s.regwrite & (s.rd != 5'd0) & (s.rd == r);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_hazard_fwd_sel.sv
// ============================================================
// Module : fwd_sel
// Desc   : Operand-select priority encoder for one source register
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module fwd_sel
   import pipes::*;
(
   input  logic       use_src,
   input  logic [4:0] src,
   input  hz_slot_t   e_slot,
   input  hz_slot_t   m_slot,
   input  hz_slot_t   w_slot,
   output forward_t   sel
);

   // Only the youngest producer needs its kind; older ones always forward writeback data.
   logic w_unused_kinds;
   assign w_unused_kinds = ^{m_slot.kind, w_slot.kind};

   always_comb begin
      sel = Rd;
      if (use_src) begin
         if (writes_reg(e_slot, src)) begin
            case (e_slot.kind)
               ALU:     sel = Result;
               LINK:    sel = PCplus4;
               default: sel = Wd;
            endcase
         end else if (writes_reg(m_slot, src)) begin
            sel = Wd;
         end else if (writes_reg(w_slot, src)) begin
            sel = Sregwd;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_hazard.sv
// ============================================================
// Module : ex_hazard
// Desc   : EX-stage load-use stall and forwarding-select control
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module ex_hazard
   import pipes::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       d_valid,
   output logic       d_ready,
   input  logic [4:0] d_rs1,
   input  logic [4:0] d_rs2,
   input  logic       d_use_rs1,
   input  logic       d_use_rs2,
   input  logic [4:0] d_rd,
   input  logic       d_regwrite,
   input  wbsrc_t     d_kind,
   input  logic       mem_stall,
   input  logic       flush,
   output logic       e_valid,
   output forward_t   e_fwd_a,
   output forward_t   e_fwd_b
);

   hz_slot_t r_e, r_m, r_w, r_s;
   hz_slot_t w_dec_slot;
   forward_t w_sel_a, w_sel_b;
   logic     w_loaduse;
   logic     w_accept;

   // The S slot only marks the tail of the tracked window; nothing reads it.
   logic w_unused_s;
   assign w_unused_s = ^r_s;

   assign w_loaduse = d_valid & (r_e.kind == LOAD)
                    & ((d_use_rs1 & writes_reg(r_e, d_rs1)) |
                       (d_use_rs2 & writes_reg(r_e, d_rs2)));

   // A redirect consumes the decode slot regardless of any load-use hazard.
   assign d_ready  = ~reset & ~mem_stall & (flush | ~w_loaduse);
   assign w_accept = d_valid & d_ready & ~flush;

   assign w_dec_slot = '{valid: 1'b1, rd: d_rd, regwrite: d_regwrite, kind: d_kind};

   fwd_sel u_fwd_a (
      .use_src (d_use_rs1),
      .src     (d_rs1),
      .e_slot  (r_e),
      .m_slot  (r_m),
      .w_slot  (r_w),
      .sel     (w_sel_a)
   );

   fwd_sel u_fwd_b (
      .use_src (d_use_rs2),
      .src     (d_rs2),
      .e_slot  (r_e),
      .m_slot  (r_m),
      .w_slot  (r_w),
      .sel     (w_sel_b)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e     <= c_empty_slot;
         r_m     <= c_empty_slot;
         r_w     <= c_empty_slot;
         r_s     <= c_empty_slot;
         e_valid <= 1'b0;
         e_fwd_a <= Rd;
         e_fwd_b <= Rd;
      end else if (!mem_stall) begin
         r_s     <= r_w;
         r_w     <= r_m;
         r_m     <= r_e;
         r_e     <= w_accept ? w_dec_slot : c_empty_slot;
         e_valid <= w_accept;
         e_fwd_a <= w_accept ? w_sel_a : Rd;
         e_fwd_b <= w_accept ? w_sel_b : Rd;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard.sv
// ============================================================
// Module : tb_ex_hazard
// Desc   : Self-checking bench for ex_hazard
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module tb_ex_hazard;
   import pipes::*;

   logic       clk, reset, d_valid, d_ready, d_use_rs1, d_use_rs2, d_regwrite;
   logic       mem_stall, flush, e_valid;
   logic [4:0] d_rs1, d_rs2, d_rd;
   wbsrc_t     d_kind;
   forward_t   e_fwd_a, e_fwd_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      bit       v;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       u1;
      bit       u2;
      bit [4:0] rd;
      bit       rw;
      wbsrc_t   kind;
   } dec_t;

   typedef struct packed {
      bit       v;
      bit [4:0] rd;
      bit       rw;
      wbsrc_t   kind;
   } ins_t;

   // hist[k] is the instruction that entered EX k advancing cycles ago.
   ins_t     hist [3];
   bit       m_ev;
   forward_t m_fa, m_fb;
   bit       exp_ready, obs_ready;

   ex_hazard dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_ready    (d_ready),
      .d_rs1      (d_rs1),
      .d_rs2      (d_rs2),
      .d_use_rs1  (d_use_rs1),
      .d_use_rs2  (d_use_rs2),
      .d_rd       (d_rd),
      .d_regwrite (d_regwrite),
      .d_kind     (d_kind),
      .mem_stall  (mem_stall),
      .flush      (flush),
      .e_valid    (e_valid),
      .e_fwd_a    (e_fwd_a),
      .e_fwd_b    (e_fwd_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic dec_t mk(bit [4:0] rd, bit rw, wbsrc_t k, bit u1, bit [4:0] rs1,
                               bit u2, bit [4:0] rs2);
      dec_t d;
      d.v = 1'b1; d.rd = rd; d.rw = rw; d.kind = k;
      d.u1 = u1; d.rs1 = rs1; d.u2 = u2; d.rs2 = rs2;
      return d;
   endfunction

   function automatic dec_t alu(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
      return mk(rd, 1'b1, ALU, 1'b1, rs1, 1'b1, rs2);
   endfunction

   function automatic dec_t lw(bit [4:0] rd, bit [4:0] rs1);
      return mk(rd, 1'b1, LOAD, 1'b1, rs1, 1'b0, 5'd0);
   endfunction

   function automatic dec_t jal(bit [4:0] rd);
      return mk(rd, 1'b1, LINK, 1'b0, 5'd0, 1'b0, 5'd0);
   endfunction

   function automatic dec_t idle();
      dec_t d;
      d = mk(5'd0, 1'b0, ALU, 1'b0, 5'd0, 1'b0, 5'd0);
      d.v = 1'b0;
      return d;
   endfunction

   function automatic ins_t empty_ins();
      ins_t e;
      e.v = 1'b0; e.rd = 5'd0; e.rw = 1'b0; e.kind = ALU;
      return e;
   endfunction

   // Nearest in-flight writer decides: 1 ahead -> by kind, 2 ahead -> Wd, 3 ahead -> Sregwd.
   function automatic forward_t ref_sel(bit u, bit [4:0] s);
      if (!u || s == 5'd0) return Rd;
      for (int k = 0; k < 3; k++) begin
         if (hist[k].v && hist[k].rw && hist[k].rd == s) begin
            if (k == 0) return (hist[0].kind == LINK) ? PCplus4 : Result;
            if (k == 1) return Wd;
            return Sregwd;
         end
      end
      return Rd;
   endfunction

   function automatic bit ref_ready(dec_t d, bit ms, bit fl, bit rst);
      bit lu;
      lu = d.v && hist[0].v && hist[0].rw && hist[0].kind == LOAD && hist[0].rd != 5'd0 &&
           ((d.u1 && d.rs1 == hist[0].rd) || (d.u2 && d.rs2 == hist[0].rd));
      return !rst && !ms && (fl || !lu);
   endfunction

   // Drives one cycle, samples d_ready before the edge, advances the model after it.
   task automatic step(input dec_t d, input bit ms, input bit fl, input bit rst);
      bit       acc;
      forward_t na, nb;
      @(negedge clk);
      reset = rst; mem_stall = ms; flush = fl;
      d_valid = d.v; d_rs1 = d.rs1; d_rs2 = d.rs2; d_use_rs1 = d.u1; d_use_rs2 = d.u2;
      d_rd = d.rd; d_regwrite = d.rw; d_kind = d.kind;
      #1;
      obs_ready = d_ready;
      exp_ready = ref_ready(d, ms, fl, rst);
      acc = d.v && exp_ready && !fl;
      na  = acc ? ref_sel(d.u1, d.rs1) : Rd;
      nb  = acc ? ref_sel(d.u2, d.rs2) : Rd;
      @(posedge clk);
      #1;
      if (rst) begin
         for (int k = 0; k < 3; k++) hist[k] = empty_ins();
         m_ev = 1'b0; m_fa = Rd; m_fb = Rd;
      end else if (!ms) begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         if (acc) begin
            hist[0].v = 1'b1; hist[0].rd = d.rd; hist[0].rw = d.rw; hist[0].kind = d.kind;
         end else begin
            hist[0] = empty_ins();
         end
         m_ev = acc; m_fa = na; m_fb = nb;
      end
   endtask

   task automatic drain();
      repeat (4) step(idle(), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) step(idle(), 1'b0, 1'b0, 1'b1);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0d want 0", obs_ready); end
      checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL reset_ev got %0d want 0", e_valid); end
      checks++; if (e_fwd_a !== Rd || e_fwd_b !== Rd) begin errors++; $display("FAIL reset_sel got a=%0d b=%0d want 0 0", e_fwd_a, e_fwd_b); end
      step(idle(), 1'b0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0d want 1", obs_ready); end
   endtask

   task automatic test_alu_fwd();
      drain();
      step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
      step(alu(5'd6, 5'd5, 5'd9), 1'b0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b1 || e_valid !== 1'b1) begin errors++; $display("FAIL alu_accept got rdy=%0d ev=%0d want 1 1", obs_ready, e_valid); end
      checks++; if (e_fwd_a !== Result || e_fwd_b !== Rd) begin errors++; $display("FAIL alu_sel got a=%0d b=%0d want 1 0", e_fwd_a, e_fwd_b); end
   endtask

   task automatic test_loaduse();
      drain();
      step(lw(5'd7, 5'd1), 1'b0, 1'b0, 1'b0);
      step(alu(5'd9, 5'd8, 5'd7), 1'b0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL lu_ready got %0d want 0", obs_ready); end
      checks++; if (e_valid !== 1'b0 || e_fwd_b !== Rd) begin errors++; $display("FAIL lu_bubble got ev=%0d b=%0d want 0 0", e_valid, e_fwd_b); end
      step(alu(5'd9, 5'd8, 5'd7), 1'b0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b1 || e_valid !== 1'b1) begin errors++; $display("FAIL lu_retry got rdy=%0d ev=%0d want 1 1", obs_ready, e_valid); end
      checks++; if (e_fwd_b !== Wd || e_fwd_a !== Rd) begin errors++; $display("FAIL lu_sel got a=%0d b=%0d want 0 2", e_fwd_a, e_fwd_b); end
   endtask

   task automatic test_link();
      drain();
      step(jal(5'd1), 1'b0, 1'b0, 1'b0);
      step(alu(5'd9, 5'd10, 5'd11), 1'b0, 1'b0, 1'b0);
      step(alu(5'd12, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0);
      checks++; if (e_fwd_a !== Wd || e_fwd_b !== Wd) begin errors++; $display("FAIL link_gap got a=%0d b=%0d want 2 2", e_fwd_a, e_fwd_b); end
      drain();
      step(jal(5'd1), 1'b0, 1'b0, 1'b0);
      step(alu(5'd12, 5'd1, 5'd1), 1'b0, 1'b0, 1'b0);
      checks++; if (e_fwd_a !== PCplus4 || e_fwd_b !== PCplus4) begin errors++; $display("FAIL link_nogap got a=%0d b=%0d want 3 3", e_fwd_a, e_fwd_b); end
   endtask

   task automatic test_distance();
      drain();
      step(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
      step(alu(5'd4, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0);
      checks++; if (e_valid !== 1'b1 || e_fwd_a !== Rd || e_fwd_b !== Rd) begin errors++; $display("FAIL x0_sel got ev=%0d a=%0d b=%0d want 1 0 0", e_valid, e_fwd_a, e_fwd_b); end
      drain();
      step(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
      step(alu(5'd20, 5'd21, 5'd22), 1'b0, 1'b0, 1'b0);
      step(alu(5'd23, 5'd21, 5'd22), 1'b0, 1'b0, 1'b0);
      step(alu(5'd24, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0);
      checks++; if (e_fwd_a !== Sregwd || e_fwd_b !== Sregwd) begin errors++; $display("FAIL dist3_sel got a=%0d b=%0d want 4 4", e_fwd_a, e_fwd_b); end
      drain();
      step(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
      step(alu(5'd20, 5'd21, 5'd22), 1'b0, 1'b0, 1'b0);
      step(alu(5'd23, 5'd21, 5'd22), 1'b0, 1'b0, 1'b0);
      step(alu(5'd25, 5'd21, 5'd22), 1'b0, 1'b0, 1'b0);
      step(alu(5'd24, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0);
      checks++; if (e_fwd_a !== Rd || e_fwd_b !== Rd) begin errors++; $display("FAIL dist4_sel got a=%0d b=%0d want 0 0", e_fwd_a, e_fwd_b); end
   endtask

   task automatic test_stall_flush();
      drain();
      step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
      step(alu(5'd6, 5'd5, 5'd9), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(alu(5'd7, 5'd5, 5'd6), 1'b1, (i == 1), 1'b0);
         checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0d want 0", i, obs_ready); end
         checks++; if (e_valid !== 1'b1 || e_fwd_a !== Result || e_fwd_b !== Rd) begin errors++; $display("FAIL stall_hold[%0d] got ev=%0d a=%0d b=%0d want 1 1 0", i, e_valid, e_fwd_a, e_fwd_b); end
      end
      step(alu(5'd7, 5'd5, 5'd6), 1'b0, 1'b1, 1'b0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0d want 1", obs_ready); end
      checks++; if (e_valid !== 1'b0 || e_fwd_a !== Rd || e_fwd_b !== Rd) begin errors++; $display("FAIL flush_bubble got ev=%0d a=%0d b=%0d want 0 0 0", e_valid, e_fwd_a, e_fwd_b); end
   endtask

   task automatic test_reset_midstall();
      drain();
      step(lw(5'd7, 5'd1), 1'b0, 1'b0, 1'b0);
      step(alu(5'd8, 5'd2, 5'd7), 1'b0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL rms_stall got %0d want 0", obs_ready); end
      step(alu(5'd8, 5'd2, 5'd7), 1'b1, 1'b1, 1'b1);
      checks++; if (e_valid !== 1'b0 || e_fwd_a !== Rd || e_fwd_b !== Rd) begin errors++; $display("FAIL rms_reset got ev=%0d a=%0d b=%0d want 0 0 0", e_valid, e_fwd_a, e_fwd_b); end
      step(alu(5'd8, 5'd2, 5'd7), 1'b0, 1'b0, 1'b0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rms_ready got %0d want 1", obs_ready); end
      checks++; if (e_valid !== 1'b1 || e_fwd_b !== Rd) begin errors++; $display("FAIL rms_empty got ev=%0d b=%0d want 1 0", e_valid, e_fwd_b); end
   endtask

   task automatic test_random();
      dec_t d;
      bit   ms, fl, rst;
      for (int n = 0; n < 400; n++) begin
         d = mk(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), wbsrc_t'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
         d.v = ($urandom_range(0, 3) != 0);
         ms  = ($urandom_range(0, 4) == 0);
         fl  = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 49) == 0);
         step(d, ms, fl, rst);
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %0d want %0d", n, obs_ready, exp_ready); end
         checks++; if (e_valid !== m_ev) begin errors++; $display("FAIL rnd_ev[%0d] got %0d want %0d", n, e_valid, m_ev); end
         checks++; if (e_fwd_a !== m_fa) begin errors++; $display("FAIL rnd_a[%0d] got %0d want %0d", n, e_fwd_a, m_fa); end
         checks++; if (e_fwd_b !== m_fb) begin errors++; $display("FAIL rnd_b[%0d] got %0d want %0d", n, e_fwd_b, m_fb); end
      end
   endtask

   initial begin
      reset = 1'b1; mem_stall = 1'b0; flush = 1'b0; d_valid = 1'b0;
      d_rs1 = 5'd0; d_rs2 = 5'd0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
      d_rd = 5'd0; d_regwrite = 1'b0; d_kind = ALU;
      for (int k = 0; k < 3; k++) hist[k] = empty_ins();
      m_ev = 1'b0; m_fa = Rd; m_fb = Rd;
      test_reset();
      test_alu_fwd();
      test_loaduse();
      test_link();
      test_distance();
      test_stall_flush();
      test_reset_midstall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
